// File: rtl/handshake_merge_reduce_pkg.sv
// Shared types and constants for the three-source merge/reduce block.
package handshake_merge_reduce_pkg;

  localparam int NUM_SRC = 3;
  localparam int CNT_W   = 8;
  localparam int DATA_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic              tuple0;
    logic              tuple1;
    logic              out;
  } beat_t;

  function automatic beat_t make_beat(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    beat_t r;
    r.in1    = a;
    r.in2    = b;
    r.tuple0 = ^b;
    r.tuple1 = |b;
    r.out    = (|a) & (&a) & (^b);
    return r;
  endfunction

endpackage

// File: rtl/handshake_fifo.sv
// Small synchronous FIFO; head is masked to zero while empty.
module handshake_fifo
  import handshake_merge_reduce_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = beat_t
) (
  input  logic CLK,
  input  logic ASYNCRESETN,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic valid,
  output logic full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= din;
  end

  assign valid = (cnt != '0);
  assign full  = (cnt == FULL_CNT);
  assign dout  = valid ? mem[rptr] : '0;

endmodule

// File: rtl/handshake_merge_reduce.sv
// Round-robin merge of three sources into a FIFO with derived reduce bits.
module handshake_merge_reduce
  import handshake_merge_reduce_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             handshake_arr_0_valid,
  input  logic             handshake_arr_1_valid,
  input  logic             handshake_arr_2_valid,
  output logic             handshake_arr_0_ready,
  output logic             handshake_arr_1_ready,
  output logic             handshake_arr_2_ready,
  input  logic [3:0]       arr_0_in1,
  input  logic [3:0]       arr_0_in2,
  input  logic [3:0]       arr_1_in1,
  input  logic [3:0]       arr_1_in2,
  input  logic [3:0]       arr_2_in1,
  input  logic [3:0]       arr_2_in2,
  output logic             handshake_valid,
  input  logic             handshake_ready,
  output logic [3:0]       in1,
  output logic [3:0]       in2,
  output logic             intermediate_tuple__0,
  output logic             intermediate_tuple__1,
  output logic             out,
  output logic [CNT_W-1:0] beat_count
);

  logic [NUM_SRC-1:0] vld;
  logic [3:0]         in1_a [NUM_SRC];
  logic [3:0]         in2_a [NUM_SRC];
  logic [1:0]         rr;
  logic [1:0]         gnt;
  logic               any;
  logic               full;
  logic               pop;
  logic               accept;
  beat_t              rec;
  beat_t              head;

  assign vld = {handshake_arr_2_valid,
                handshake_arr_1_valid,
                handshake_arr_0_valid};

  assign in1_a[0] = arr_0_in1;
  assign in1_a[1] = arr_1_in1;
  assign in1_a[2] = arr_2_in1;
  assign in2_a[0] = arr_0_in2;
  assign in2_a[1] = arr_1_in2;
  assign in2_a[2] = arr_2_in2;

  // rr names the source with highest priority this cycle
  always_comb begin
    any = |vld;
    gnt = 2'd0;
    unique case (rr)
      2'd1:    gnt = vld[1] ? 2'd1 : (vld[2] ? 2'd2 : 2'd0);
      2'd2:    gnt = vld[2] ? 2'd2 : (vld[0] ? 2'd0 : 2'd1);
      default: gnt = vld[0] ? 2'd0 : (vld[1] ? 2'd1 : 2'd2);
    endcase
  end

  assign pop    = handshake_valid & handshake_ready;
  assign accept = ASYNCRESETN & any & (~full | pop);

  assign handshake_arr_0_ready = accept & (gnt == 2'd0);
  assign handshake_arr_1_ready = accept & (gnt == 2'd1);
  assign handshake_arr_2_ready = accept & (gnt == 2'd2);

  assign rec = make_beat(in1_a[gnt], in2_a[gnt]);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      rr         <= 2'd0;
      beat_count <= '0;
    end else begin
      if (accept) rr <= (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
      if (pop)    beat_count <= beat_count + 1'b1;
    end
  end

  handshake_fifo #(
    .DEPTH (DEPTH),
    .T     (beat_t)
  ) u_fifo (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .push        (accept),
    .din         (rec),
    .pop         (pop),
    .dout        (head),
    .valid       (handshake_valid),
    .full        (full)
  );

  assign in1                   = head.in1;
  assign in2                   = head.in2;
  assign intermediate_tuple__0 = head.tuple0;
  assign intermediate_tuple__1 = head.tuple1;
  assign out                   = head.out;

endmodule

// File: tb/tb_handshake_merge_reduce.sv
// Directed bench for handshake_merge_reduce with immediate assertions.
module tb_handshake_merge_reduce;

  logic       CLK;
  logic       ASYNCRESETN;
  logic       v0, v1, v2;
  logic       r0, r1, r2;
  logic [3:0] a0_in1, a0_in2, a1_in1, a1_in2, a2_in1, a2_in2;
  logic       hvalid;
  logic       hready;
  logic [3:0] in1, in2;
  logic       t0, t1, o;
  logic [7:0] beat_count;

  int checks;
  int failures;

  handshake_merge_reduce #(.DEPTH(2)) dut (
    .CLK                   (CLK),
    .ASYNCRESETN           (ASYNCRESETN),
    .handshake_arr_0_valid (v0),
    .handshake_arr_1_valid (v1),
    .handshake_arr_2_valid (v2),
    .handshake_arr_0_ready (r0),
    .handshake_arr_1_ready (r1),
    .handshake_arr_2_ready (r2),
    .arr_0_in1             (a0_in1),
    .arr_0_in2             (a0_in2),
    .arr_1_in1             (a1_in1),
    .arr_1_in2             (a1_in2),
    .arr_2_in1             (a2_in1),
    .arr_2_in2             (a2_in2),
    .handshake_valid       (hvalid),
    .handshake_ready       (hready),
    .in1                   (in1),
    .in2                   (in2),
    .intermediate_tuple__0 (t0),
    .intermediate_tuple__1 (t1),
    .out                   (o),
    .beat_count            (beat_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ASYNCRESETN = 1'b0;
    {v0, v1, v2} = 3'b000;
    hready = 1'b0;
    a0_in1 = '0; a0_in2 = '0;
    a1_in1 = '0; a1_in2 = '0;
    a2_in1 = '0; a2_in2 = '0;

    // reset state
    tick();
    tick();
    chk("rst_valid", 32'(hvalid), 32'd0);
    chk("rst_beat", 32'(beat_count), 32'd0);
    chk("rst_in1", 32'(in1), 32'd0);
    chk("rst_ready", 32'({r2, r1, r0}), 32'd0);
    ASYNCRESETN = 1'b1;
    tick();

    // single source 1
    v1 = 1'b1; a1_in1 = 4'hF; a1_in2 = 4'h1; hready = 1'b1;
    #1;
    chk("single_rdy", 32'({r2, r1, r0}), 32'b010);
    tick();
    v1 = 1'b0;
    chk("single_valid", 32'(hvalid), 32'd1);
    chk("single_in1", 32'(in1), 32'hF);
    chk("single_in2", 32'(in2), 32'h1);
    chk("single_out", 32'(o), 32'd1);
    chk("single_t0", 32'(t0), 32'd1);
    chk("single_t1", 32'(t1), 32'd1);
    tick();
    chk("single_beat", 32'(beat_count), 32'd1);
    chk("single_empty", 32'(hvalid), 32'd0);

    // fairness from a fresh reset
    ASYNCRESETN = 1'b0;
    #2;
    ASYNCRESETN = 1'b1;
    tick();
    a0_in1 = 4'h1; a1_in1 = 4'h2; a2_in1 = 4'h3;
    a0_in2 = 4'h0; a1_in2 = 4'h0; a2_in2 = 4'h0;
    {v0, v1, v2} = 3'b111;
    hready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("fair_rdy%0d", k), 32'({r2, r1, r0}),
          32'(1 << (k % 3)));
      tick();
      chk($sformatf("fair_head%0d", k), 32'(in1), 32'((k % 3) + 1));
    end
    {v0, v1, v2} = 3'b000;
    tick();
    chk("fair_beat", 32'(beat_count), 32'd6);
    chk("fair_empty", 32'(hvalid), 32'd0);

    // backpressure with source 0
    hready = 1'b0;
    v0 = 1'b1; a0_in1 = 4'h4; a0_in2 = 4'h1;
    #1;
    chk("bp_rdyA", 32'(r0), 32'd1);
    tick();
    a0_in1 = 4'h5; a0_in2 = 4'h2;
    #1;
    chk("bp_rdyB", 32'(r0), 32'd1);
    tick();
    a0_in1 = 4'h6; a0_in2 = 4'h3;
    #1;
    chk("bp_rdyC_full", 32'(r0), 32'd0);
    tick();
    chk("bp_hold_rdy", 32'(r0), 32'd0);
    chk("bp_hold_in1", 32'(in1), 32'h4);
    chk("bp_hold_in2", 32'(in2), 32'h1);
    tick();
    chk("bp_stable_in1", 32'(in1), 32'h4);
    chk("bp_stable_valid", 32'(hvalid), 32'd1);
    hready = 1'b1;
    #1;
    chk("bp_rdyC_pop", 32'(r0), 32'd1);
    tick();
    v0 = 1'b0;
    chk("bp_drainB", 32'(in1), 32'h5);
    tick();
    chk("bp_drainC", 32'(in1), 32'h6);
    chk("bp_drainC_t1", 32'(t1), 32'd1);
    tick();
    chk("bp_empty", 32'(hvalid), 32'd0);
    chk("bp_beat", 32'(beat_count), 32'd9);

    // full FIFO with simultaneous push and pop
    hready = 1'b0;
    v0 = 1'b1; a0_in1 = 4'h7; a0_in2 = 4'h0;
    tick();
    a0_in1 = 4'h8;
    tick();
    v0 = 1'b0;
    v2 = 1'b1; a2_in1 = 4'h9; a2_in2 = 4'h0;
    hready = 1'b1;
    #1;
    chk("fpp_rdy2", 32'({r2, r1, r0}), 32'b100);
    tick();
    v2 = 1'b0;
    hready = 1'b0;
    v0 = 1'b1; a0_in1 = 4'hA;
    #1;
    chk("fpp_still_full", 32'(r0), 32'd0);
    chk("fpp_head", 32'(in1), 32'h8);
    v0 = 1'b0;
    hready = 1'b1;
    tick();
    chk("fpp_drain9", 32'(in1), 32'h9);
    tick();
    chk("fpp_empty", 32'(hvalid), 32'd0);
    chk("fpp_beat", 32'(beat_count), 32'd12);

    // reset mid-stream with two beats held
    hready = 1'b0;
    v1 = 1'b1; a1_in1 = 4'hA; a1_in2 = 4'h5;
    tick();
    a1_in1 = 4'hB;
    tick();
    chk("mid_pre_valid", 32'(hvalid), 32'd1);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk("mid_valid", 32'(hvalid), 32'd0);
    chk("mid_beat", 32'(beat_count), 32'd0);
    chk("mid_in1", 32'(in1), 32'd0);
    chk("mid_in2", 32'(in2), 32'd0);
    chk("mid_out", 32'({o, t1, t0}), 32'd0);
    chk("mid_ready", 32'({r2, r1, r0}), 32'd0);
    v1 = 1'b0;
    tick();
    ASYNCRESETN = 1'b1;
    tick();
    chk("mid_discard", 32'(hvalid), 32'd0);

    // beat_count wrap over 256 pops
    hready = 1'b1;
    v0 = 1'b1; a0_in1 = 4'hE; a0_in2 = 4'h3;
    tick();
    chk("wrap_out", 32'(o), 32'd0);
    chk("wrap_t0", 32'(t0), 32'd0);
    chk("wrap_t1", 32'(t1), 32'd1);
    chk("wrap_in1", 32'(in1), 32'hE);
    for (int k = 0; k < 255; k++) tick();
    chk("wrap_255", 32'(beat_count), 32'd255);
    v0 = 1'b0;
    tick();
    chk("wrap_zero", 32'(beat_count), 32'd0);
    chk("wrap_empty", 32'(hvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/handshake_merge_reduce.md
HANDSHAKE_MERGE_REDUCE -- requirements
Module: handshake_merge_reduce

Interface
REQ-001 SHALL have parameter DEPTH, default 2, output FIFO entries (power of two, 2..8).
REQ-002 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-003 SHALL have port ASYNCRESETN  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports handshake_arr_i_valid (i=0..2)  input  1  source i offers a beat.
REQ-005 SHALL have ports handshake_arr_i_ready (i=0..2)  output  1  source i beat accepted this cycle.
REQ-006 SHALL have ports arr_i_in1, arr_i_in2 (i=0..2)  input  4 each  source i payload.
REQ-007 SHALL have port handshake_valid  output  1  FIFO head valid.
REQ-008 SHALL have port handshake_ready  input  1  downstream consumer (monitor-observed) accepts.
REQ-009 SHALL have ports in1, in2  output  4 each  head payload.
REQ-010 SHALL have ports intermediate_tuple__0, intermediate_tuple__1, out  output  1 each  head derived bits.
REQ-011 SHALL have port beat_count  output  8  count of output beats delivered.

Function
REQ-012 SHALL perform round-robin arbitration among valid sources; priority starts at the source after the last granted one; first grant after reset favours source 0.
REQ-013 SHALL assert at most one handshake_arr_i_ready per cycle, and only when that source is valid, is granted, and the FIFO is not full or is popping in the same cycle.
REQ-014 SHALL hold the round-robin pointer unchanged in cycles with no accepted beat.
REQ-015 SHALL compute on accept: intermediate_tuple__0 = XOR-reduce of in2; intermediate_tuple__1 = OR-reduce of in2; out = (OR-reduce in1) AND (AND-reduce in1) AND intermediate_tuple__0; derived bits SHALL be stored alongside the payload.
REQ-016 SHALL make accepted beats visible on outputs one cycle later (latency 1 into an empty FIFO); no combinational path from arr_i inputs to in1/in2/out.
REQ-017 SHALL pop the head when handshake_valid and handshake_ready are both high; payload SHALL hold stable while valid is high and ready is low.
REQ-018 SHALL treat simultaneous push and pop when full as legal (occupancy unchanged); when empty, push and pop do not coincide (head not yet valid).
REQ-019 SHALL wrap read/write pointers modulo DEPTH; full = occupancy DEPTH, empty = occupancy 0.
REQ-020 SHALL increment beat_count by 1 per pop, wrapping 255 -> 0.
REQ-021 SHALL preserve per-source order; cross-source order follows grant order.

Reset
REQ-022 SHALL on ASYNCRESETN low immediately clear: FIFO occupancy, pointers, handshake_valid=0, all handshake_arr_i_ready=0, beat_count=0, round-robin pointer to source 0.
REQ-023 SHALL drive in1, in2, out, intermediate_tuple__0/1 to 0 during reset.
REQ-024 SHALL discard in-flight FIFO contents when reset asserts mid-operation; first cycle after release accepts nothing until CLK edge samples a valid source.

Structure
REQ-025 SHALL place the beat record typedef (in1, in2, tuple0, tuple1, out), NUM_SRC=3 and the beat_count width in a shared package.
REQ-026 SHALL implement the FIFO as sub-module handshake_fifo, parameterised by DEPTH and record type.

Verification
REQ-027 Reset: assert ASYNCRESETN low mid-stream with FIFO holding 2 beats -> same cycle handshake_valid=0, beat_count=0, all outputs 0.
REQ-028 Single source: source 1 sends in1=4'hF, in2=4'h1, ready held high -> next cycle handshake_valid=1, in1=F, out=1, tuple0=1, tuple1=1.
REQ-029 Fairness: all three valid continuously, ready high -> grants 0,1,2,0,1,2; beat_count=6 after six pops.
REQ-030 Backpressure: handshake_ready low, source 0 sends 3 beats with DEPTH=2 -> two accepted, third held (ready_0=0), payload stable; raising ready drains in order.
REQ-031 Full push+pop: FIFO full, ready=1, source 2 valid -> source 2 accepted, occupancy stays 2.
REQ-032 Wrap: 256 pops -> beat_count returns to 0; in1=4'hE, in2=4'h3 -> out=0, tuple0=0.
